// File: rtl/bus_arbiter_if.sv
// Bus bundle for bus_arbiter.
// It carries both master request ports, the shared slave port, and the status outputs.
// The slave modport is the arbiter's view.
// The master modport is the surrounding system's view: the masters, the memory side and the monitors.
//
// Handshake: a master raises mN_cyc_i together with valid we/addr/data/sel.
// It keeps cyc_i high until it sees a one-cycle mN_ack_o or mN_err_o.
// The arbiter samples the request fields only in the cycle it grants that master.
// On the memory side, s_cyc_o stays high until the slave answers with s_ack_i for one cycle,
// or until the timeout ends the transaction.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              m0_cyc_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_data_i;
  logic [3:0]        m0_sel_i;
  logic [DATA_W-1:0] m0_data_o;
  logic              m0_ack_o;
  logic              m0_err_o;

  logic              m1_cyc_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i;
  logic [3:0]        m1_sel_i;
  logic [DATA_W-1:0] m1_data_o;
  logic              m1_ack_o;
  logic              m1_err_o;

  logic              s_cyc_o;
  logic              s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_data_o;
  logic [3:0]        s_sel_o;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ack_i;

  logic [1:0]        grant_o;
  logic              busy_o;
  // Debug view of the arbiter FSM state: 0 idle, 1 grant0, 2 grant1, 3 done.
  logic [1:0]        arb_state;

  modport slave (
    input  m0_cyc_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
    input  m1_cyc_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i,
    input  s_data_i, s_ack_i,
    output m0_data_o, m0_ack_o, m0_err_o,
    output m1_data_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
    output grant_o, busy_o, arb_state
  );

  modport master (
    output m0_cyc_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
    output m1_cyc_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i,
    output s_data_i, s_ack_i,
    input  m0_data_o, m0_ack_o, m0_err_o,
    input  m1_data_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
    input  grant_o, busy_o, arb_state
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter.
// Master 0 (data access) has fixed priority.
// A starvation guard hands the bus to master 1 (instruction fetch) after MAX_BURST consecutive
// master-0 grants taken while master 1 was waiting.
// Each transaction is latched at grant and completes through a one-cycle DONE state.
// A per-transaction timeout turns a silent slave into an error pulse.
module bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  localparam int              SW         = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(MAX_BURST);
  localparam logic [15:0]     TO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [15:0]       to_cnt;
  logic [SW-1:0]     starve_cnt;

  logic              s_cyc;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic [3:0]        s_sel;
  logic [DATA_W-1:0] m0_data;
  logic [DATA_W-1:0] m1_data;
  logic              m0_ack;
  logic              m1_ack;
  logic              m0_err;
  logic              m1_err;
  logic [1:0]        grant;
  logic              busy;

  logic              pick_m0;
  logic              pick_m1;

  // Master 0 wins unless master 1 is also waiting and has already been passed over MAX_BURST times.
  assign pick_m0 = bus.m0_cyc_i && !(bus.m1_cyc_i && (starve_cnt == STARVE_MAX));
  assign pick_m1 = bus.m1_cyc_i && !pick_m0;

  // Arbitration FSM. Every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      starve_cnt <= '0;
      s_cyc      <= 1'b0;
      s_we       <= 1'b0;
      s_addr     <= '0;
      s_data     <= '0;
      s_sel      <= '0;
      m0_data    <= '0;
      m1_data    <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (pick_m0) begin
            state  <= GRANT0;
            s_cyc  <= 1'b1;
            s_we   <= bus.m0_we_i;
            s_addr <= bus.m0_addr_i;
            s_data <= bus.m0_data_i;
            s_sel  <= bus.m0_sel_i;
            grant  <= 2'b01;
            busy   <= 1'b1;
            if (bus.m1_cyc_i && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (pick_m1) begin
            state      <= GRANT1;
            s_cyc      <= 1'b1;
            s_we       <= bus.m1_we_i;
            s_addr     <= bus.m1_addr_i;
            s_data     <= bus.m1_data_i;
            s_sel      <= bus.m1_sel_i;
            grant      <= 2'b10;
            busy       <= 1'b1;
            starve_cnt <= '0;
          end
        end
        GRANT0, GRANT1: begin
          // A slave ack beats a timeout that expires in the same cycle.
          if (bus.s_ack_i) begin
            if (state == GRANT0) begin
              m0_data <= bus.s_data_i;
              m0_ack  <= 1'b1;
            end else begin
              m1_data <= bus.s_data_i;
              m1_ack  <= 1'b1;
            end
            s_cyc <= 1'b0;
            state <= DONE;
          end else if (to_cnt == TO_LAST) begin
            if (state == GRANT0) begin
              m0_data <= '0;
              m0_err  <= 1'b1;
            end else begin
              m1_data <= '0;
              m1_err  <= 1'b1;
            end
            s_cyc <= 1'b0;
            state <= DONE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        DONE: begin
          // The finishing master sees its pulse in this cycle.
          // Its cyc_i is not arbitrated until IDLE.
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_cyc_o   = s_cyc;
  assign bus.s_we_o    = s_we;
  assign bus.s_addr_o  = s_addr;
  assign bus.s_data_o  = s_data;
  assign bus.s_sel_o   = s_sel;
  assign bus.m0_data_o = m0_data;
  assign bus.m1_data_o = m1_data;
  assign bus.m0_ack_o  = m0_ack;
  assign bus.m1_ack_o  = m1_ack;
  assign bus.m0_err_o  = m0_err;
  assign bus.m1_err_o  = m1_err;
  assign bus.grant_o   = grant;
  assign bus.busy_o    = busy;
  assign bus.arb_state = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter.
// Directed steps cover reset, a single read, the starvation pattern, timeout, ack/timeout collision
// and reset in mid-transaction.
// A randomized phase follows. The reference model works per transaction.
// It picks the winner from the priority/starvation rule, and the ack or error timing comes from
// the slave's wait count.
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TIMEOUT  (TO),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  int         tests = 0;
  int         failed = 0;
  int         streak = 0;      // m0 grants since the last m1 grant that were taken while m1 waited
  int         last_lat = 0;    // grant-state cycles until the completion pulse
  logic [1:0] exp_q[$];        // expected grant vectors
  int         win_hist[$];     // observed winners
  int         starve_seq[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule.
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return (streak >= MB) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic rand_master(input int m);
    if (m == 0) begin
      bus.m0_we_i   = 1'($urandom_range(0, 1));
      bus.m0_addr_i = AW'($urandom);
      bus.m0_data_i = DW'($urandom);
      bus.m0_sel_i  = 4'($urandom_range(0, 15));
    end else begin
      bus.m1_we_i   = 1'($urandom_range(0, 1));
      bus.m1_addr_i = AW'($urandom);
      bus.m1_data_i = DW'($urandom);
      bus.m1_sel_i  = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic set_cyc(input int m, input bit v);
    if (m == 0) bus.m0_cyc_i = v;
    else        bus.m1_cyc_i = v;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_scyc"},  bus.s_cyc_o,   0);
    chk({tag, "_grant"}, bus.grant_o,   0);
    chk({tag, "_busy"},  bus.busy_o,    0);
    chk({tag, "_ack0"},  bus.m0_ack_o,  0);
    chk({tag, "_ack1"},  bus.m1_ack_o,  0);
    chk({tag, "_err0"},  bus.m0_err_o,  0);
    chk({tag, "_err1"},  bus.m1_err_o,  0);
  endtask

  task automatic check_reset_regs(input string tag);
    check_quiet(tag);
    chk({tag, "_swe"},   bus.s_we_o,    0);
    chk({tag, "_saddr"}, bus.s_addr_o,  0);
    chk({tag, "_sdata"}, bus.s_data_o,  0);
    chk({tag, "_ssel"},  bus.s_sel_o,   0);
    chk({tag, "_d0"},    bus.m0_data_o, 0);
    chk({tag, "_d1"},    bus.m1_data_o, 0);
  endtask

  // One arbitration from IDLE through DONE and back to IDLE.
  // waits is the number of cycles before the slave acks; waits >= TO means the slave never acks.
  // next_req is what the winner drives on cyc_i in its DONE cycle: 0, 1, or 2 for random.
  task automatic do_txn(input int waits, input logic [DW-1:0] rdata, input bit wiggle, input int next_req);
    int              w;
    bit              r0;
    bit              r1;
    bit              done;
    logic            ewe;
    logic [AW-1:0]   ea;
    logic [DW-1:0]   ed;
    logic [3:0]      es;
    logic            ack_w;
    logic            err_w;
    logic            ack_x;
    logic            err_x;
    logic [DW-1:0]   dat_w;
    r0 = bus.m0_cyc_i;
    r1 = bus.m1_cyc_i;
    w  = pick(r0, r1);
    if (w < 0) begin
      tick;
      check_quiet("idle");
      return;
    end
    ewe = (w == 0) ? bus.m0_we_i   : bus.m1_we_i;
    ea  = (w == 0) ? bus.m0_addr_i : bus.m1_addr_i;
    ed  = (w == 0) ? bus.m0_data_i : bus.m1_data_i;
    es  = (w == 0) ? bus.m0_sel_i  : bus.m1_sel_i;
    exp_q.push_back((w == 0) ? 2'b01 : 2'b10);
    if (w == 1) streak = 0;
    else if (r1 && streak < MB) streak++;
    tick;
    chk("grant", bus.grant_o, exp_q.pop_front());
    chk("grant_scyc",  bus.s_cyc_o,  1);
    chk("grant_busy",  bus.busy_o,   1);
    chk("grant_swe",   bus.s_we_o,   ewe);
    chk("grant_saddr", bus.s_addr_o, ea);
    chk("grant_sdata", bus.s_data_o, ed);
    chk("grant_ssel",  bus.s_sel_o,  es);
    win_hist.push_back((bus.grant_o == 2'b10) ? 1 : 0);
    done = 1'b0;
    for (int k = 0; k < TO && !done; k++) begin
      if (wiggle) begin
        rand_master(0);
        rand_master(1);
        if ($urandom_range(0, 3) == 0) set_cyc(w, 1'b0);
      end
      bus.s_ack_i  = (k == waits);
      bus.s_data_i = (k == waits) ? rdata : DW'($urandom);
      tick;
      ack_w = (w == 0) ? bus.m0_ack_o  : bus.m1_ack_o;
      err_w = (w == 0) ? bus.m0_err_o  : bus.m1_err_o;
      ack_x = (w == 0) ? bus.m1_ack_o  : bus.m0_ack_o;
      err_x = (w == 0) ? bus.m1_err_o  : bus.m0_err_o;
      dat_w = (w == 0) ? bus.m0_data_o : bus.m1_data_o;
      chk("other_ack", ack_x, 0);
      chk("other_err", err_x, 0);
      if (k == waits) begin
        chk("ack",      ack_w,       1);
        chk("ack_err",  err_w,       0);
        chk("ack_data", dat_w,       rdata);
        chk("ack_scyc", bus.s_cyc_o, 0);
        done = 1'b1;
        last_lat = k + 1;
      end else if (k == TO - 1) begin
        chk("to_err",  err_w,       1);
        chk("to_ack",  ack_w,       0);
        chk("to_data", dat_w,       0);
        chk("to_scyc", bus.s_cyc_o, 0);
        done = 1'b1;
        last_lat = k + 1;
      end else begin
        chk("wait_ack",   ack_w,        0);
        chk("wait_err",   err_w,        0);
        chk("wait_scyc",  bus.s_cyc_o,  1);
        chk("wait_saddr", bus.s_addr_o, ea);
        chk("wait_sdata", bus.s_data_o, ed);
        chk("wait_swe",   bus.s_we_o,   ewe);
      end
    end
    bus.s_ack_i = 1'b0;
    if (next_req == 2) set_cyc(w, 1'($urandom_range(0, 1)));
    else               set_cyc(w, next_req[0]);
    tick;
    check_quiet("done");
  endtask

  // Stimulus and checks
  initial begin
    starve_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bus.s_ack_i  = 1'b0;
    bus.s_data_i = '0;
    rand_master(0);
    rand_master(1);
    bus.m0_cyc_i = 1'b1;
    bus.m1_cyc_i = 1'b1;

    // Reset held with both masters requesting
    #2 rst = 1'b0;
    repeat (3) tick;
    check_reset_regs("rst");
    rst = 1'b1;
    // m0 wins the first arbitration and then leaves; m1 keeps waiting
    do_txn(0, DW'($urandom), 1'b0, 0);

    // Single read by m1 with two wait cycles
    bus.m1_addr_i = 32'h0000_1000;
    bus.m1_we_i   = 1'b0;
    do_txn(2, 32'hDEAD_BEEF, 1'b0, 0);
    chk("read_lat", last_lat, 3);

    // Starvation guard, both masters requesting continuously, zero-wait slave
    win_hist.delete();
    bus.m0_cyc_i = 1'b1;
    bus.m1_cyc_i = 1'b1;
    for (int i = 0; i < 10; i++) do_txn(0, DW'($urandom), 1'b0, 1);
    for (int i = 0; i < 10; i++) chk("starve_seq", win_hist[i], starve_seq[i]);

    // Timeout on an m0 write while m1 waits
    bus.m0_we_i = 1'b1;
    do_txn(TO + 2, DW'($urandom), 1'b0, 0);
    chk("to_lat", last_lat, TO);
    win_hist.delete();
    do_txn(0, DW'($urandom), 1'b0, 0);
    chk("to_then_m1", win_hist[0], 1);

    // Nobody requesting
    do_txn(0, DW'($urandom), 1'b0, 0);

    // Ack arriving in the same cycle as the timeout
    bus.m0_cyc_i = 1'b1;
    do_txn(TO - 1, 32'hC0FF_EE11, 1'b0, 0);

    // Reset in the middle of a GRANT0 transaction
    bus.m0_cyc_i = 1'b1;
    tick;
    chk("mid_grant", bus.grant_o, 2'b01);
    chk("mid_scyc",  bus.s_cyc_o, 1);
    tick;
    rst = 1'b0;
    #1;
    check_reset_regs("mid_rst");
    repeat (2) begin
      tick;
      check_quiet("mid_hold");
    end
    streak = 0;
    rst = 1'b1;
    do_txn(1, 32'h1234_5678, 1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if (!bus.m0_cyc_i && $urandom_range(0, 1) == 1) begin
        rand_master(0);
        bus.m0_cyc_i = 1'b1;
      end
      if (!bus.m1_cyc_i && $urandom_range(0, 1) == 1) begin
        rand_master(1);
        bus.m1_cyc_i = 1'b1;
      end
      do_txn(int'($urandom_range(0, TO + 1)), DW'($urandom), 1'b1, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
